// File: rtl/blink_pkg.sv
// Shared types and constants for the blink_sequencer LED/debug-pin pattern player.
// Optional PWM brightness is enabled with the BLINK_PWM_EN macro.
package blink_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int NUM_CH_DEF    = 4;
  localparam int PATTERN_W_DEF = 32;
  localparam int CH_W          = $clog2(NUM_CH_DEF);
  localparam int IDX_W         = $clog2(PATTERN_W_DEF);

  // Morse SOS, LSB first, with trailing zero steps as the inter-word gap.
  localparam logic [PATTERN_W_DEF-1:0] SOS_PATTERN = 32'b101010001110111011100010101;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running step prescaler: counts 0..TICK_DIV-1 and pulses tick_o on the last count.
module blink_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/blink_sequencer.sv
// Multi-channel pattern blinker with per-channel valid/ready pattern loading.
// Define BLINK_PWM_EN to add the cfg_bright input and 16-step PWM dimming of led.
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int                   NUM_CH          = NUM_CH_DEF,
  parameter int                   PATTERN_W       = PATTERN_W_DEF,
  parameter int                   TICK_DIV        = 2097152,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(SOS_PATTERN)
) (
  input  logic                         CLK_CPU,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
  input  logic [PATTERN_W-1:0]         cfg_pattern,
  input  logic [$clog2(PATTERN_W)-1:0] cfg_len,
  input  logic                         cfg_oneshot,
`ifdef BLINK_PWM_EN
  input  logic [3:0]                   cfg_bright,
`endif
  input  logic [NUM_CH-1:0]            clear,
  output logic [NUM_CH-1:0]            led,
  output logic [NUM_CH-1:0]            done
);

  localparam int CW = $clog2(NUM_CH);
  localparam int IW = $clog2(PATTERN_W);

  logic              tick;
  logic [NUM_CH-1:0] pend_vec;

  blink_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk_i (CLK_CPU),
    .rst_ni(reset),
    .tick_o(tick)
  );

`ifdef BLINK_PWM_EN
  logic [3:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + 4'd1;

  always_ff @(posedge CLK_CPU or negedge reset) begin
    if (!reset) pwm_q <= 4'd0;
    else        pwm_q <= pwm_d;
  end
`endif

  always_comb begin
    cfg_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == CW'(c)) cfg_ready = !pend_vec[c] && !clear[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam ch_state_e              RST_ST  = (c == 0) ? RUN : IDLE;
    localparam logic [PATTERN_W-1:0] RST_PAT = (c == 0) ? DEFAULT_PATTERN : '0;
    localparam logic [IW-1:0]        RST_LEN = (c == 0) ? IW'(PATTERN_W - 1) : '0;

    ch_state_e            st_q, st_d;
    logic [PATTERN_W-1:0] pat_q, pat_d, ppat_q, ppat_d;
    logic [IW-1:0]        len_q, len_d, plen_q, plen_d, idx_q, idx_d;
    logic                 os_q, os_d, pos_q, pos_d;
    logic                 pend_q, pend_d, done_q, done_d, led_q, led_d;
    logic                 accept;
`ifdef BLINK_PWM_EN
    logic [3:0]           br_q, br_d, pbr_q, pbr_d;
`endif

    assign accept      = cfg_valid && cfg_ready && (cfg_ch == CW'(c));
    assign pend_vec[c] = pend_q;
    assign led[c]      = led_q;
    assign done[c]     = done_q;

    always_comb begin
      st_d   = st_q;
      pat_d  = pat_q;
      len_d  = len_q;
      idx_d  = idx_q;
      os_d   = os_q;
      pend_d = pend_q;
      ppat_d = ppat_q;
      plen_d = plen_q;
      pos_d  = pos_q;
      done_d = 1'b0;
`ifdef BLINK_PWM_EN
      br_d   = br_q;
      pbr_d  = pbr_q;
`endif
      if (clear[c]) begin
        st_d   = IDLE;
        pend_d = 1'b0;
        idx_d  = '0;
      end else begin
        if (accept) begin
          pend_d = 1'b1;
          ppat_d = cfg_pattern;
          plen_d = cfg_len;
          pos_d  = cfg_oneshot;
`ifdef BLINK_PWM_EN
          pbr_d  = cfg_bright;
`endif
        end
        // A pending load always wins over stepping at the tick boundary.
        if (tick) begin
          if (pend_q) begin
            st_d   = RUN;
            pat_d  = ppat_q;
            len_d  = plen_q;
            os_d   = pos_q;
            idx_d  = '0;
            pend_d = 1'b0;
`ifdef BLINK_PWM_EN
            br_d   = pbr_q;
`endif
          end else if (st_q == RUN) begin
            if (idx_q < len_q) begin
              idx_d = idx_q + IW'(1);
            end else if (!os_q) begin
              idx_d = '0;
            end else begin
              st_d   = IDLE;
              idx_d  = '0;
              done_d = 1'b1;
            end
          end
        end
      end
`ifdef BLINK_PWM_EN
      led_d = (st_d == RUN) && pat_d[idx_d] && (pwm_d < br_d);
`else
      led_d = (st_d == RUN) && pat_d[idx_d];
`endif
    end

    always_ff @(posedge CLK_CPU or negedge reset) begin
      if (!reset) begin
        st_q   <= RST_ST;
        pat_q  <= RST_PAT;
        len_q  <= RST_LEN;
        idx_q  <= '0;
        os_q   <= 1'b0;
        pend_q <= 1'b0;
        ppat_q <= '0;
        plen_q <= '0;
        pos_q  <= 1'b0;
        done_q <= 1'b0;
        led_q  <= 1'b0;
`ifdef BLINK_PWM_EN
        br_q   <= (c == 0) ? 4'hF : 4'h0;
        pbr_q  <= 4'h0;
`endif
      end else begin
        st_q   <= st_d;
        pat_q  <= pat_d;
        len_q  <= len_d;
        idx_q  <= idx_d;
        os_q   <= os_d;
        pend_q <= pend_d;
        ppat_q <= ppat_d;
        plen_q <= plen_d;
        pos_q  <= pos_d;
        done_q <= done_d;
        led_q  <= led_d;
`ifdef BLINK_PWM_EN
        br_q   <= br_d;
        pbr_q  <= pbr_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer with TICK_DIV=4, NUM_CH=4, PATTERN_W=32.
`timescale 1ns/1ps
module tb_blink_sequencer;

  logic        CLK_CPU, reset, cfg_valid, cfg_ready, cfg_oneshot;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic [3:0]  cfg_bright, clear, led, done;

  int          total, bad, cyc;
  logic [31:0] def_v;
  logic [3:0]  pat1;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] clr;
    logic       exp_rdy;
  } rdy_vec_t;
  rdy_vec_t tbl[8];

  blink_sequencer #(.TICK_DIV(4)) dut (
    .CLK_CPU    (CLK_CPU),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_oneshot(cfg_oneshot),
`ifdef BLINK_PWM_EN
    .cfg_bright (cfg_bright),
`endif
    .clear      (clear),
    .led        (led),
    .done       (done)
  );

  initial begin
    CLK_CPU = 1'b0;
    forever #10 CLK_CPU = ~CLK_CPU;
  end

  function automatic logic pwm_on(int c, int b);
`ifdef BLINK_PWM_EN
    return (c % 16) < b;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [3:0] exp_vec(int c, logic l1, logic l2, logic l3);
    logic [3:0] v;
    v[0] = def_v[(c / 4) % 32] & pwm_on(c, 15);
    v[1] = l1 & pwm_on(c, 15);
    v[2] = l2 & pwm_on(c, 15);
    v[3] = l3 & pwm_on(c, 4);
    return v;
  endfunction

  function automatic logic l1_b(int c);
    if (c >= 140 && c < 156) return pat1[(c - 140) / 4];
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle(logic [3:0] exp_led, logic [3:0] exp_done);
    chk("led", {28'b0, led}, {28'b0, exp_led});
    chk("done", {28'b0, done}, {28'b0, exp_done});
  endtask

  task automatic step();
    @(posedge CLK_CPU);
    #1;
    cyc++;
  endtask

  task automatic load(logic [1:0] ch, logic [31:0] pat, logic [4:0] len, logic os, logic [3:0] br);
    cfg_valid   = 1'b1;
    cfg_ch      = ch;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_oneshot = os;
    cfg_bright  = br;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    def_v = 32'b101010001110111011100010101;
    pat1  = 4'b1011;
    tbl[0] = '{2'd0, 4'b0000, 1'b1};
    tbl[1] = '{2'd1, 4'b0000, 1'b0};
    tbl[2] = '{2'd2, 4'b0000, 1'b1};
    tbl[3] = '{2'd3, 4'b0000, 1'b1};
    tbl[4] = '{2'd2, 4'b0100, 1'b0};
    tbl[5] = '{2'd0, 4'b0001, 1'b0};
    tbl[6] = '{2'd3, 4'b0100, 1'b1};
    tbl[7] = '{2'd1, 4'b0010, 1'b0};

    cfg_valid = 0; cfg_ch = 0; cfg_pattern = 0; cfg_len = 0; cfg_oneshot = 0;
    cfg_bright = 0; clear = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_led", {28'b0, led}, 32'h0);
    chk("rst_done", {28'b0, done}, 32'h0);
    chk("rst_ready", {31'b0, cfg_ready}, 32'h1);
    step(); step();
    reset = 1'b1;
    cyc = 0;

    // Default SOS on channel 0, including the wrap after 32 steps.
    while (cyc < 136) begin
      step();
      check_cycle(exp_vec(cyc, 1'b0, 1'b0, 1'b0), 4'b0);
    end

    // One-shot load on ch1 right after a tick, then a second request while pending.
    load(2'd1, 32'b1011, 5'd3, 1'b1, 4'hF);
    chk("rdy_first", {31'b0, cfg_ready}, 32'h1);
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_ch = tbl[i].ch;
      clear  = tbl[i].clr;
      #1;
      chk($sformatf("rdy_tbl%0d", i), {31'b0, cfg_ready}, {31'b0, tbl[i].exp_rdy});
    end
    clear = 4'b0;
    load(2'd1, 32'b0100, 5'd3, 1'b1, 4'hF);
    #1;
    check_cycle(exp_vec(cyc, l1_b(cyc), 1'b0, 1'b0), 4'b0);
    chk("rdy_pend", {31'b0, cfg_ready}, 32'h0);
    while (cyc < 139) begin
      step();
      check_cycle(exp_vec(cyc, l1_b(cyc), 1'b0, 1'b0), 4'b0);
      chk("rdy_pend", {31'b0, cfg_ready}, 32'h0);
    end
    step();
    check_cycle(exp_vec(cyc, l1_b(cyc), 1'b0, 1'b0), 4'b0);
    chk("rdy_install", {31'b0, cfg_ready}, 32'h1);
    cfg_valid = 1'b0;
    while (cyc < 157) begin
      step();
      check_cycle(exp_vec(cyc, l1_b(cyc), 1'b0, 1'b0), (cyc == 156) ? 4'b0010 : 4'b0);
    end

    // Loop load ch2 with a one-bit pattern, then clear racing a new request.
    load(2'd2, 32'h1, 5'd0, 1'b0, 4'hF);
    chk("rdy_ch2", {31'b0, cfg_ready}, 32'h1);
    step();
    cfg_valid = 1'b0;
    while (cyc < 163) begin
      check_cycle(exp_vec(cyc, 1'b0, (cyc >= 160), 1'b0), 4'b0);
      step();
    end
    check_cycle(exp_vec(cyc, 1'b0, 1'b1, 1'b0), 4'b0);
    clear = 4'b0100;
    load(2'd2, 32'h0, 5'd0, 1'b0, 4'hF);
    #1;
    chk("rdy_clear", {31'b0, cfg_ready}, 32'h0);
    step();
    check_cycle(exp_vec(cyc, 1'b0, 1'b0, 1'b0), 4'b0);
    clear = 4'b0;
    cfg_valid = 1'b0;
    #1;
    chk("no_xfer", {31'b0, cfg_ready}, 32'h1);
    while (cyc < 169) begin
      step();
      check_cycle(exp_vec(cyc, 1'b0, 1'b0, 1'b0), 4'b0);
    end

    // One-shot on ch1, then an asynchronous reset in the middle of it.
    load(2'd1, 32'b0111, 5'd3, 1'b1, 4'hF);
    step();
    cfg_valid = 1'b0;
    cfg_ch = 2'd0;
    while (cyc < 173) begin
      check_cycle(exp_vec(cyc, (cyc >= 172), 1'b0, 1'b0), 4'b0);
      step();
    end
    check_cycle(exp_vec(cyc, 1'b1, 1'b0, 1'b0), 4'b0);
    #2 reset = 1'b0;
    #1;
    chk("async_led", {28'b0, led}, 32'h0);
    chk("async_done", {28'b0, done}, 32'h0);
    chk("async_ready", {31'b0, cfg_ready}, 32'h1);
    step(); step();
    chk("hold_led", {28'b0, led}, 32'h0);
    reset = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      step();
      check_cycle(exp_vec(cyc, 1'b0, 1'b0, 1'b0), 4'b0);
    end

    // Loop all-ones on ch3 at brightness 4.
    load(2'd3, 32'hFFFF_FFFF, 5'd31, 1'b0, 4'd4);
    step();
    cfg_valid = 1'b0;
    while (cyc < 76) begin
      check_cycle(exp_vec(cyc, 1'b0, 1'b0, (cyc >= 44)), 4'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
